// File: rtl/pool_upsampler.sv
// Streaming nearest-neighbour un-pooler: (M/P)x(M/P) raster in, MxM raster out, valid/ready on both sides.
// Define ZERO_FILL_EN for max-unpool output (only block top-left carries the value, no row buffer).
module pool_upsampler #(
    parameter int M     = 12,
    parameter int P     = 3,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             external_reset,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             end_op
);

    localparam int N  = M / P;
    localparam int SW = $clog2(P);
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {FILL, REPLAY} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   sub, sub_nxt, rib, rib_nxt;
    logic [NW-1:0]   bcol, bcol_nxt, band, band_nxt;
    logic            adv, need, step, last_pix;
    logic [WIDTH-1:0] pix;

`ifndef ZERO_FILL_EN
    logic [WIDTH-1:0] row_buf [N];
`endif

    always_ff @(posedge clk or posedge external_reset) begin
        if (external_reset) begin
            state <= FILL;
            sub   <= '0;
            bcol  <= '0;
            rib   <= '0;
            band  <= '0;
        end else if (step) begin
            state <= state_nxt;
            sub   <= sub_nxt;
            bcol  <= bcol_nxt;
            rib   <= rib_nxt;
            band  <= band_nxt;
        end
    end

    // Nested wrap: sub -> bcol -> rib (row within band) -> band; frame wrap lands back in FILL.
    always_comb begin
        state_nxt = state;
        sub_nxt   = sub;
        bcol_nxt  = bcol;
        rib_nxt   = rib;
        band_nxt  = band;
        if (sub == SW'(P - 1)) begin
            sub_nxt = '0;
            if (bcol == NW'(N - 1)) begin
                bcol_nxt = '0;
                if (rib == SW'(P - 1)) begin
                    rib_nxt   = '0;
                    state_nxt = FILL;
                    band_nxt  = (band == NW'(N - 1)) ? '0 : band + NW'(1);
                end else begin
                    rib_nxt   = rib + SW'(1);
                    state_nxt = REPLAY;
                end
            end else begin
                bcol_nxt = bcol + NW'(1);
            end
        end else begin
            sub_nxt = sub + SW'(1);
        end
    end

    always_comb begin
        adv      = ce & (~out_valid | out_ready);
        need     = (state == FILL) && (sub == '0);
        in_ready = adv & need & ~external_reset;
        step     = adv & (~need | in_valid);
        last_pix = (sub == SW'(P - 1)) && (bcol == NW'(N - 1)) &&
                   (rib == SW'(P - 1)) && (band == NW'(N - 1));
`ifdef ZERO_FILL_EN
        pix = need ? data_in : '0;
`else
        pix = need ? data_in : row_buf[bcol];
`endif
    end

    // A bubble (need without in_valid) drops out_valid but keeps data_out and the counters.
    always_ff @(posedge clk or posedge external_reset) begin
        if (external_reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            end_op    <= 1'b0;
        end else if (adv) begin
            out_valid <= step;
            end_op    <= step & last_pix;
            if (step) data_out <= pix;
        end
    end

`ifndef ZERO_FILL_EN
    always_ff @(posedge clk or posedge external_reset) begin
        if (external_reset) begin
            for (int unsigned i = 0; i < N; i++) row_buf[i] <= '0;
        end else if (adv && need && in_valid) begin
            row_buf[bcol] <= data_in;
        end
    end
`endif

endmodule

// File: tb/tb_pool_upsampler.sv
// Self-checking bench for pool_upsampler (M=12, P=3, WIDTH=16) against an index-arithmetic reference.
// Honours ZERO_FILL_EN the same way as the design.
module tb_pool_upsampler;

    localparam int M = 12;
    localparam int P = 3;
    localparam int N = M / P;
    localparam int FR = M * M;

    logic        clk = 1'b0;
    logic        external_reset;
    logic        ce, in_valid, out_ready;
    logic        in_ready, out_valid, end_op;
    logic [15:0] data_in, data_out;

    pool_upsampler #(.M(M), .P(P), .WIDTH(16)) dut (
        .clk            (clk),
        .external_reset (external_reset),
        .ce             (ce),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .end_op         (end_op)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: src holds the pooled values in send order, frame k at src[16k..].
    int src [256];
    int in_ptr, frame_base, gen, cur_val, frames_done, cons_in_frame;
    bit exp_valid, cur_end, tog;

    function automatic int golden(input int base, input int k);
        int r, c;
        r = k / M;
        c = k % M;
`ifdef ZERO_FILL_EN
        if ((r % P) != 0 || (c % P) != 0) return 0;
`endif
        return src[base + (r / P) * N + (c / P)];
    endfunction

    function automatic bit need_at(input int k);
        return ((k / M) % P == 0) && ((k % M) % P == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        in_ptr = 0; frame_base = 0; gen = 0; cur_val = 0;
        exp_valid = 0; cur_end = 0; cons_in_frame = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        external_reset = 1'b1;
        ce = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_end_op", 32'(end_op), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        ce = 1'b0; in_valid = 1'b0;
        external_reset = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input bit ce_v, input bit iv, input bit ordy);
        bit nd, adv;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("data_out", 32'(data_out), 32'(cur_val));
            chk("end_op", 32'(end_op), 32'(cur_end));
        end else begin
            chk("end_op_idle", 32'(end_op), 32'(0));
        end
        ce = ce_v; in_valid = iv; out_ready = ordy;
        data_in = 16'(src[in_ptr]);
        #1;
        nd  = need_at(gen);
        adv = ce_v && (!exp_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(adv && nd));
        @(posedge clk);
        if (ce_v && exp_valid && ordy) begin
            cons_in_frame++;
            if (cur_end) begin frames_done++; cons_in_frame = 0; end
        end
        if (adv) begin
            if (nd && !iv) begin
                exp_valid = 0;
            end else begin
                if (nd) in_ptr++;
                cur_val   = golden(frame_base, gen);
                cur_end   = (gen == FR - 1);
                exp_valid = 1;
                gen++;
                if (gen == FR) begin gen = 0; frame_base += N * N; end
            end
        end
    endtask

    // mode: 0 full rate, 1 out_ready toggling, 2 input gap before input 6,
    //       3 ce pause mid-band, 4 random, 5 full rate stopping after 50 pixels
    task automatic run(input int target, input int mode);
        int start, n, gap, pause;
        bit c, v, o, done;
        start = frames_done; n = 0; gap = 0; pause = 0; tog = 1; done = 0;
        while (n < 2000 && !done) begin
            c = 1; v = 1; o = 1;
            case (mode)
                1: begin o = tog; tog = !tog; end
                2: if (in_ptr == frame_base + 5 && gap < 4) begin v = 0; gap++; end
                3: if (gen == 20 && pause < 5) begin c = 0; pause++; end
                4: begin
                    c = ($urandom_range(0, 7) != 0);
                    v = ($urandom_range(0, 3) != 0);
                    o = ($urandom_range(0, 2) != 0);
                end
                default: ;
            endcase
            cycle(c, v, o);
            n++;
            done = (mode == 5) ? (cons_in_frame >= 50) : (frames_done >= start + target);
        end
        chk("timeout", 32'(done), 32'(1));
    endtask

    initial begin
        external_reset = 1'b0;
        ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        frames_done = 0;
        for (int i = 0; i < 256; i++)
            src[i] = (i < 2 * N * N) ? (i % (N * N)) + 1 : int'($urandom_range(0, 65535));
        model_reset();

        do_reset();
        run(1, 0);
        run(1, 1);
        run(1, 2);
        run(1, 3);
        run(1, 5);
        do_reset();
        for (int i = 0; i < N * N; i++) src[i] = i + 1;
        run(1, 0);
        run(2, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
